// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serialises a CMD_WIDTH-bit command as CMD_WIDTH/8 back-to-back UART frames, MSB byte first.
// Latency: start bit on tx the cycle after accept; done pulses the cycle after the last stop bit.
// Backpressure: cmd_rdy is low for the whole command; cmd_vld while not ready is dropped, nothing queued.
//
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   cmd_in/cmd_vld/cmd_rdy - command word with valid/ready handshake
//   tx                  - registered serial line, idle high
//   busy, done          - command in flight / one-cycle completion pulse
module uart_cmd_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int CMD_WIDTH = 16,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CMD_WIDTH-1:0] cmd_in,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV    = CLK_FREQ / BAUD;
  localparam int NBYTES = CMD_WIDTH / 8;
  localparam int CW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic ODD_PAR = (PARITY == 2);

  if (DIV < 2) begin : g_div_chk
    $error("uart_cmd_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if ((CMD_WIDTH == 0) || (CMD_WIDTH % 8 != 0)) begin : g_width_chk
    $error("uart_cmd_tx: CMD_WIDTH must be a non-zero multiple of 8");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_par_chk
    $error("uart_cmd_tx: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_chk
    $error("uart_cmd_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        baud_cnt_q;
  logic [CW-1:0]        baud_cnt_d;
  logic [2:0]           bit_cnt_q;
  logic [2:0]           bit_cnt_d;
  logic [BCW-1:0]       byte_cnt_q;
  logic [CMD_WIDTH-1:0] shift_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 baud_end;
  logic [7:0]           cur_byte;

  // The byte on the line is always the top byte; the register shifts left
  // by a byte between frames.
  assign cur_byte   = shift_q[CMD_WIDTH-1 -: 8];
  assign baud_end   = (baud_cnt_q == CW'(DIV - 1));
  assign baud_cnt_d = baud_end ? '0 : baud_cnt_q + CW'(1);
  assign bit_cnt_d  = bit_cnt_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_vld) begin
            shift_q    <= cmd_in;
            state_q    <= S_START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
          end
        end
        S_START: begin
          baud_cnt_q <= baud_cnt_d;
          if (baud_end) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            tx_q      <= cur_byte[0];
          end
        end
        S_DATA: begin
          baud_cnt_q <= baud_cnt_d;
          if (baud_end) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PAR;
                tx_q    <= (^cur_byte) ^ ODD_PAR;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_d;
              tx_q      <= cur_byte[bit_cnt_d];
            end
          end
        end
        S_PAR: begin
          baud_cnt_q <= baud_cnt_d;
          if (baud_end) begin
            state_q   <= S_STOP;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
          end
        end
        S_STOP: begin
          baud_cnt_q <= baud_cnt_d;
          if (baud_end) begin
            if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
              bit_cnt_q <= '0;
              if (byte_cnt_q == BCW'(NBYTES - 1)) begin
                // Last stop bit done: back to idle with a completion pulse.
                state_q    <= S_IDLE;
                byte_cnt_q <= '0;
                tx_q       <= 1'b1;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                // Next byte starts immediately, no idle gap.
                state_q    <= S_START;
                byte_cnt_q <= byte_cnt_q + BCW'(1);
                shift_q    <= shift_q << 8;
                tx_q       <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign cmd_rdy = ~busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb_uart_cmd_tx: directed scoreboard bench for uart_cmd_tx across four parameter sets.
// Frames are decoded mid-bit from tx and matched against hand-computed frames;
// done pulses are matched against expected cycle, busy length and idle outputs.
module tb_uart_cmd_tx;

  logic        clk;
  logic        rst_n;
  logic [31:0] cmd_r;
  logic        vld_r  [4];
  logic        tx_w   [4];
  logic        busy_w [4];
  logic        done_w [4];
  logic        rdy_w  [4];
  int          cyc;
  int          n_chk;
  int          n_fail;

  // Frame bits in transmission order, first bit in the MSB.
  typedef struct {int d; logic [10:0] f;} frm_t;
  typedef struct {int d; int cyc; int bsy;} dn_t;
  frm_t fq[$];
  dn_t  dq[$];

  // 0: 16-bit even, 1: 8-bit odd, 2: 8-bit no parity 2 stop, 3: 32-bit even
  uart_cmd_tx #(.CLK_FREQ(1000000), .BAUD(100000), .CMD_WIDTH(16), .PARITY(1), .STOP_BITS(1)) u16 (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_r[15:0]), .cmd_vld(vld_r[0]), .cmd_rdy(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_cmd_tx #(.CLK_FREQ(1000000), .BAUD(100000), .CMD_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u8o (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_r[7:0]), .cmd_vld(vld_r[1]), .cmd_rdy(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_cmd_tx #(.CLK_FREQ(1000000), .BAUD(100000), .CMD_WIDTH(8), .PARITY(0), .STOP_BITS(2)) u8n (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_r[7:0]), .cmd_vld(vld_r[2]), .cmd_rdy(rdy_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_cmd_tx #(.CLK_FREQ(1000000), .BAUD(100000), .CMD_WIDTH(32), .PARITY(1), .STOP_BITS(1)) u32 (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_r), .cmd_vld(vld_r[3]), .cmd_rdy(rdy_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame and done monitors, one pair per DUT. Every configuration has an
  // 11-bit frame at 10 cycles per bit; bits are sampled in their 5th cycle.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial begin
      logic [10:0] fr;
      bit          aborted;
      frm_t        e;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx_w[g] === 1'b0) begin
          fr      = '0;
          aborted = 1'b0;
          for (int c = 0; c < 110; c++) begin
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (c % 10 == 4) fr = {fr[9:0], tx_w[g]};
            if (c != 109) @(negedge clk);
          end
          if (!aborted) begin
            if (fq.size() == 0) begin
              chk($sformatf("frame_unexpected_dut%0d", g), {21'd0, fr}, 32'hFFFF_FFFF);
            end else begin
              e = fq.pop_front();
              chk($sformatf("frame_dut_id_dut%0d", g), g, e.d);
              chk($sformatf("frame_bits_dut%0d", g), {21'd0, fr}, {21'd0, e.f});
            end
          end
        end
      end
    end

    initial begin
      int  bcnt;
      dn_t e;
      bcnt = 0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) bcnt = 0;
        else if (busy_w[g] === 1'b1) bcnt++;
        if (done_w[g] === 1'b1) begin
          if (dq.size() == 0) begin
            chk($sformatf("done_unexpected_dut%0d", g), 32'd1, 32'd0);
          end else begin
            e = dq.pop_front();
            chk($sformatf("done_dut_id_dut%0d", g), g, e.d);
            chk($sformatf("done_cycle_dut%0d", g), cyc, e.cyc);
            chk($sformatf("busy_cycles_dut%0d", g), bcnt, e.bsy);
            chk($sformatf("done_outs_dut%0d", g), {busy_w[g], rdy_w[g], tx_w[g]}, 3'b011);
          end
          bcnt = 0;
        end
      end
    end
  end

  task automatic push_frame(input int d, input logic [10:0] f);
    frm_t e;
    e.d = d;
    e.f = f;
    fq.push_back(e);
  endtask

  // Called on a negedge. Presents the command, waits for acceptance, and
  // returns the cycle number of the accept edge. lat = 0 means no done is
  // expected (command will be cut by reset).
  task automatic send(input int d, input logic [31:0] c, input int lat, input bit hold,
                      output int acc);
    int  n;
    dn_t e;
    cmd_r    = c;
    vld_r[d] = 1'b1;
    n        = 0;
    while (rdy_w[d] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk($sformatf("accept_timeout_dut%0d", d), n, 0);
      vld_r[d] = 1'b0;
      acc      = cyc;
      return;
    end
    @(negedge clk);
    if (!hold) vld_r[d] = 1'b0;
    acc = cyc;
    chk($sformatf("start_bit_dut%0d", d), {busy_w[d], rdy_w[d], tx_w[d]}, 3'b100);
    if (lat > 0) begin
      e.d   = d;
      e.cyc = acc + lat;
      e.bsy = lat;
      dq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((fq.size() != 0 || dq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", n, 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    int a0;
    int a1;
    int n;
    int rdy_hi;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    cmd_r  = '0;
    for (int i = 0; i < 4; i++) vld_r[i] = 1'b0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_outs_dut%0d", i),
          {tx_w[i], rdy_w[i], busy_w[i], done_w[i]}, 4'b1100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 16-bit even parity, 16'hA55A.
    push_frame(0, 11'b01010010101);
    push_frame(0, 11'b00101101001);
    send(0, 32'h0000_A55A, 220, 1'b0, a0);
    wait_idle();

    // 8-bit odd parity: 03 -> parity 1, 01 -> parity 0.
    push_frame(1, 11'b01100000011);
    send(1, 32'h0000_0003, 110, 1'b0, a0);
    wait_idle();
    push_frame(1, 11'b01000000001);
    send(1, 32'h0000_0001, 110, 1'b0, a0);
    wait_idle();

    // 8-bit no parity, 2 stop bits: FF gives 11 bits with no parity slot.
    push_frame(2, 11'b01111111111);
    send(2, 32'h0000_00FF, 110, 1'b0, a0);
    wait_idle();

    // Back-to-back with cmd_vld held: 1234 then ABCD.
    push_frame(0, 11'b00100100001);
    push_frame(0, 11'b00010110011);
    push_frame(0, 11'b01101010111);
    push_frame(0, 11'b01011001111);
    send(0, 32'h0000_1234, 220, 1'b1, a0);
    send(0, 32'h0000_ABCD, 220, 1'b0, a1);
    chk("b2b_accept_in_done_cycle", a1, a0 + 221);
    wait_idle();

    // Busy ignore: FFFF pulsed during the first byte of 0000.
    push_frame(0, 11'b00000000001);
    push_frame(0, 11'b00000000001);
    send(0, 32'h0000_0000, 220, 1'b0, a0);
    repeat (30) @(negedge clk);
    cmd_r    = 32'h0000_FFFF;
    vld_r[0] = 1'b1;
    @(negedge clk);
    vld_r[0] = 1'b0;
    rdy_hi   = 0;
    n        = 0;
    while (done_w[0] !== 1'b1 && n < 400) begin
      if (rdy_w[0] !== 1'b0) rdy_hi++;
      @(negedge clk);
      n++;
    end
    chk("busy_ignore_rdy_low", rdy_hi, 0);
    chk("busy_ignore_done_seen", n < 400, 1'b1);
    wait_idle();

    // Wide command, bytes 11,22,33,44 in order.
    push_frame(3, 11'b01000100001);
    push_frame(3, 11'b00100010001);
    push_frame(3, 11'b01100110001);
    push_frame(3, 11'b00010001001);
    send(3, 32'h1122_3344, 440, 1'b0, a0);
    wait_idle();

    // Reset mid-frame during the data bits of byte 0; cmd_vld raised in the
    // same cycle as reset must not be accepted.
    send(0, 32'h0000_C3C3, 0, 1'b0, a0);
    repeat (40) @(negedge clk);
    rst_n    = 1'b0;
    cmd_r    = 32'h0000_FFFF;
    vld_r[0] = 1'b1;
    @(negedge clk);
    chk("reset_midframe_outs", {tx_w[0], rdy_w[0], busy_w[0], done_w[0]}, 4'b1100);
    vld_r[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("reset_no_pending_done", dq.size(), 0);

    // Recovery after reset: 16'h00FF.
    push_frame(0, 11'b00000000001);
    push_frame(0, 11'b01111111101);
    send(0, 32'h0000_00FF, 220, 1'b0, a0);
    wait_idle();

    chk("frames_left", fq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
